ac_key_frame_builder: RTL and testbench

Upstream front end of the IR remote transmitter. It debounces the five front-panel keys and keeps the air-conditioner state register: power, mode, set temperature and fan speed. On each effective key press it assembles the 35-bit + 32-bit command frame and offers it to the IR transmit stage over a valid/ready handshake. The transmit stage consumes `ir_data35`/`ir_data32` and drives the carrier.

---
 rtl/ac_key_frame_builder_if.sv | 12 +
 rtl/ac_key_frame_builder.sv | 129 ++++++++++++
 tb/tb_ac_key_frame_builder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ac_key_frame_builder_if.sv
// Frame handshake between the key/frame builder (master) and the IR transmit stage (slave).
// A frame transfers on a rising edge with frame_valid and frame_ready both high; the master
// keeps frame_valid and both data words stable until then and never retracts an offer.
interface ac_key_frame_builder_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [34:0] ir_data35;
  logic [31:0] ir_data32;

  modport master (output frame_valid, output ir_data35, output ir_data32, input frame_ready);
  modport slave  (input frame_valid, input ir_data35, input ir_data32, output frame_ready);
endinterface

// File: rtl/ac_key_frame_builder.sv
// Debounces the five AC front-panel keys, keeps the power/mode/temp/fan state and
// offers one IR command frame per effective press, coalescing presses made during an offer.
module ac_key_frame_builder #(
  parameter int DEBOUNCE_CYCLES = 800000,
  parameter int TEMP_RESET      = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_power,
  input  logic                          key_mode,
  input  logic                          key_temp_up,
  input  logic                          key_temp_down,
  input  logic                          key_fan,
  ac_key_frame_builder_if.master        frame,
  output logic                          led_out,
  output logic [1:0]                    fsm_state
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    OFFER = 2'd2
  } state_t;

  // Key index: 0 power, 1 mode, 2 temp up, 3 temp down, 4 fan (also the priority order).
  logic [4:0]    keys_raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    level;
  logic [4:0]    press;
  logic [CW-1:0] cnt [5];

  state_t        state;
  logic          pending;
  logic          power;
  logic [2:0]    mode;
  logic [4:0]    temp;
  logic [1:0]    fan;
  logic          valid_q;
  logic [34:0]   d35_q;
  logic [31:0]   d32_q;

  logic [3:0]    temp_code;
  logic [34:0]   frame35;
  logic [3:0]    checksum;

  assign keys_raw = {key_fan, key_temp_down, key_temp_up, key_mode, key_power};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= keys_raw;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]   <= '0;
          level[i] <= sync2[i];
          press[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign temp_code = 4'(temp - 5'd16);
  assign frame35   = {3'b010, 4'b1010, 16'd0, temp_code, 2'b00, fan, power, mode};
  assign checksum  = frame35[3:0] + temp_code + 4'd10;

  // Event handling follows the FSM case so a press in the LOAD cycle re-arms pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      power   <= 1'b0;
      mode    <= 3'd0;
      temp    <= 5'(TEMP_RESET);
      fan     <= 2'd0;
      valid_q <= 1'b0;
      d35_q   <= '0;
      d32_q   <= '0;
    end else begin
      case (state)
        IDLE: if (pending) state <= LOAD;
        LOAD: begin
          d35_q   <= frame35;
          d32_q   <= {checksum, 28'd0};
          pending <= 1'b0;
          valid_q <= 1'b1;
          state   <= OFFER;
        end
        OFFER: if (frame.frame_ready) begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (press[0]) begin
        power   <= ~power;
        pending <= 1'b1;
      end else if (power && (|press[4:1])) begin
        pending <= 1'b1;
        if (press[1])      mode <= (mode == 3'd4) ? 3'd0 : mode + 3'd1;
        else if (press[2]) temp <= (temp == 5'd30) ? temp : temp + 5'd1;
        else if (press[3]) temp <= (temp == 5'd16) ? temp : temp - 5'd1;
        else               fan  <= fan + 2'd1;
      end
    end
  end

  assign frame.frame_valid = valid_q;
  assign frame.ir_data35   = d35_q;
  assign frame.ir_data32   = d32_q;
  assign led_out           = power;
  assign fsm_state         = state;

endmodule

// File: tb/tb_ac_key_frame_builder.sv
// Self-checking bench for ac_key_frame_builder: key presses are applied to a behavioural
// model of the AC state, and accepted frames are compared against the model's frames.
module tb_ac_key_frame_builder;

  localparam int DB   = 4;
  localparam int W    = 67;
  localparam int HOLD = DB + 8;
  localparam int GAP  = DB + 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] keys = 5'd0;
  logic       led_out;
  logic [1:0] fsm_state;

  ac_key_frame_builder_if fif();

  ac_key_frame_builder #(.DEBOUNCE_CYCLES(DB), .TEMP_RESET(26)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_power     (keys[0]),
    .key_mode      (keys[1]),
    .key_temp_up   (keys[2]),
    .key_temp_down (keys[3]),
    .key_fan       (keys[4]),
    .frame         (fif),
    .led_out       (led_out),
    .fsm_state     (fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  int m_power = 0;
  int m_mode  = 0;
  int m_temp  = 26;
  int m_fan   = 0;

  // Inputs are held from a negedge to the following posedge, so this records exactly
  // the frames that the next rising edge accepts.
  always @(negedge clk) begin
    if (rst && fif.frame_valid && fif.frame_ready)
      obs_q.push_back({fif.ir_data35, fif.ir_data32});
  end

  function automatic logic [W-1:0] model_frame();
    logic [34:0] d35;
    logic [31:0] d32;
    int cks;
    d35 = 35'h2_A000_0000 + 35'((m_temp - 16) * 256 + m_fan * 16 + m_power * 8 + m_mode);
    cks = (m_power * 8 + m_mode + (m_temp - 16) + 10) % 16;
    d32 = 32'(cks) << 28;
    return {d35, d32};
  endfunction

  // Returns 1 when the press changes (or re-syncs) the unit and so asks for a frame.
  function automatic bit model_press(input logic [4:0] m);
    if (m[0]) begin
      m_power = 1 - m_power;
      return 1'b1;
    end
    if (m_power == 0 || m == 5'd0) return 1'b0;
    if (m[1])      m_mode = (m_mode + 1) % 5;
    else if (m[2]) m_temp = (m_temp < 30) ? m_temp + 1 : 30;
    else if (m[3]) m_temp = (m_temp > 16) ? m_temp - 1 : 16;
    else           m_fan  = (m_fan + 1) % 4;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] m);
    keys = m;
    repeat (HOLD) tick();
    keys = 5'd0;
    repeat (GAP) tick();
  endtask

  task automatic press_model(input logic [4:0] m);
    if (model_press(m)) exp_q.push_back(model_frame());
    press(m);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 300 && obs_q.size() < n; i++) tick();
    repeat (15) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fif.frame_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++; if (fif.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fif.frame_valid); end
    checks++; if (fif.ir_data35 !== 35'd0) begin errors++; $display("FAIL reset_d35: got %h want 0", fif.ir_data35); end
    checks++; if (fif.ir_data32 !== 32'd0) begin errors++; $display("FAIL reset_d32: got %h want 0", fif.ir_data32); end
    checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL reset_led: got %b want 0", led_out); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
  endtask

  task automatic test_power_on();
    int lat;
    logic [W-1:0] e, o;
    lat = -1;
    void'(model_press(5'b00001));
    exp_q.push_back(model_frame());
    keys = 5'b00001;
    // The first negedge after driving precedes the edge that samples the rise.
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (fif.frame_valid) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat != DB + 6) begin errors++; $display("FAIL power_latency: got %0d want %0d", lat, DB + 6); end
    repeat (4) tick();
    keys = 5'd0;
    repeat (GAP) tick();
    wait_frames(1);
    checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL power_led: got %b want 1", led_out); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL power_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL power_frame: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_power_off_discard();
    logic [W-1:0] e, o;
    press_model(5'b00001);
    press_model(5'b00100);
    wait_frames(1);
    checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL off_led: got %b want 0", led_out); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL off_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL off_frame: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_temp_saturation();
    logic [W-1:0] e, o;
    logic [3:0] codes [7];
    int idx;
    codes = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd14, 4'd14};
    press_model(5'b00001);
    for (int i = 0; i < 6; i++) press_model(5'b00100);
    for (int i = 0; i < 15; i++) press_model(5'b01000);
    wait_frames(22);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL temp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL temp_frame%0d: got %h want %h", idx, o, e); end
      if (idx < 7) begin
        checks++; if (o[43:40] !== codes[idx]) begin errors++; $display("FAIL temp_code%0d: got %0d want %0d", idx, o[43:40], codes[idx]); end
      end
      idx++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bounce();
    logic [W-1:0] e, o;
    for (int i = 0; i < 2; i++) begin
      keys = 5'b00010; repeat (2) tick();
      keys = 5'b00000; repeat (2) tick();
    end
    void'(model_press(5'b00010));
    exp_q.push_back(model_frame());
    press(5'b00010);
    wait_frames(1);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bounce_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL bounce_frame: got %h want %h", o, e); end
      checks++; if (o[34:32] !== 3'd1) begin errors++; $display("FAIL bounce_mode: got %0d want 1", o[34:32]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [W-1:0] e, o;
    logic [4:0] m;
    for (int n = 0; n < 20; n++) begin
      m = 5'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) m = m | 5'(1 << $urandom_range(0, 4));
      press_model(m);
    end
    wait_frames(exp_q.size());
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL random_frame: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall_coalesce();
    logic [W-1:0] e, o, snap;
    fif.frame_ready = 1'b1;
    if (m_power == 0) press_model(5'b00001);
    while (m_fan != 0) press_model(5'b10000);
    wait_frames(exp_q.size());
    exp_q.delete(); obs_q.delete();

    fif.frame_ready = 1'b0;
    press_model(5'b00010);
    for (int i = 0; i < 50 && !fif.frame_valid; i++) tick();
    checks++; if (fif.frame_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", fif.frame_valid); end
    snap = {fif.ir_data35, fif.ir_data32};
    for (int k = 0; k < 2; k++) begin
      void'(model_press(5'b10000));
      press(5'b10000);
      checks++; if (fif.frame_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid%0d: got %b want 1", k, fif.frame_valid); end
      checks++; if ({fif.ir_data35, fif.ir_data32} !== snap) begin errors++; $display("FAIL stall_hold_data%0d: got %h want %h", k, {fif.ir_data35, fif.ir_data32}, snap); end
    end
    exp_q.push_back(model_frame());
    fif.frame_ready = 1'b1;
    wait_frames(2);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stall_frame: got %h want %h", o, e); end
      if (exp_q.size() == 0) begin
        checks++; if (o[37:36] !== 2'd2) begin errors++; $display("FAIL stall_fan: got %0d want 2", o[37:36]); end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_priority_and_reset();
    logic [W-1:0] e, o;
    int seen;
    fif.frame_ready = 1'b1;
    if (m_power == 0) press_model(5'b00001);
    press_model(5'b00110);
    wait_frames(exp_q.size());
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL prio_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL prio_frame: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();

    fif.frame_ready = 1'b0;
    press(5'b10000);
    for (int i = 0; i < 50 && !fif.frame_valid; i++) tick();
    checks++; if (fif.frame_valid !== 1'b1) begin errors++; $display("FAIL rst_offer_valid: got %b want 1", fif.frame_valid); end
    rst = 1'b0;
    #1;
    checks++; if (fif.frame_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", fif.frame_valid); end
    checks++; if (fif.ir_data35 !== 35'd0) begin errors++; $display("FAIL rst_async_d35: got %h want 0", fif.ir_data35); end
    checks++; if (fif.ir_data32 !== 32'd0) begin errors++; $display("FAIL rst_async_d32: got %h want 0", fif.ir_data32); end
    checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL rst_async_led: got %b want 0", led_out); end
    repeat (3) tick();
    rst = 1'b1;
    m_power = 0; m_mode = 0; m_temp = 26; m_fan = 0;
    exp_q.delete(); obs_q.delete();
    fif.frame_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fif.frame_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_no_frame: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fif.frame_ready = 1'b1;
    test_reset();
    test_power_on();
    test_power_off_discard();
    test_temp_saturation();
    test_bounce();
    test_random();
    test_stall_coalesce();
    test_priority_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
